// File: rtl/sipo_rx_pkg.sv
// sipo_rx_pkg: shared defaults and pointer-width helper for the serial receiver and its PISO counterpart
//   DEF_WIDTH  default bits per word
//   DEF_DEPTH  default FIFO entries (power of 2, >= 2)
//   ptr_w()    FIFO pointer width: address bits plus one wrap bit
package sipo_rx_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/sipo_rx_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with wrap-bit pointers
//   clk, rst_n_i  clock, async active-low reset
//   push, wdata   write strobe and word (ignored while full)
//   full          no free entry
//   pop           consume head (ignored while empty)
//   rdata         head word, forced to 0 while empty
//   empty         no stored word
//   count         stored words, 0..DEPTH
module sync_fifo import sipo_rx_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n_i,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;
    assign empty   = wr_ptr == rd_ptr;
    // same slot but opposite lap means every entry is occupied
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end
    // storage needs no reset: it is never observed while empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/sipo_rx.sv
// sipo_rx: serial-in/parallel-out receiver assembling WIDTH-bit words into a FWFT FIFO
//   clk, rst_n_i       clock, async active-low reset
//   d_i, valid_i       serial bit and its valid
//   ready_o            bit can be accepted (only the completing bit stalls on a full FIFO)
//   d_o, valid_o       head word and its valid
//   ready_i            consumer takes d_o
//   count_o            words held in the FIFO
module sipo_rx import sipo_rx_pkg::*; #(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n_i,
    input  logic                   d_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [WIDTH-1:0]       d_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [CW-1:0]    bit_cnt;
    logic             last, full, empty, accept;
    assign last    = bit_cnt == CW'(WIDTH - 1);
    assign ready_o = !(full && last);
    assign accept  = valid_i && ready_o;
    // after WIDTH shifts the first bit sits at the MSB or LSB depending on direction
    assign sr_nxt  = MSB_FIRST ? {sr[WIDTH-2:0], d_i} : {d_i, sr[WIDTH-1:1]};
    assign valid_o = !empty;
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            sr      <= sr_nxt;
            bit_cnt <= last ? '0 : bit_cnt + 1'b1;
        end
    end
    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n_i (rst_n_i),
        .push    (accept && last),
        .wdata   (sr_nxt),
        .full    (full),
        .pop     (ready_i),
        .rdata   (d_o),
        .empty   (empty),
        .count   (count_o)
    );
endmodule

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx: randomized and directed checks of sipo_rx (both bit orders) against a queue-based model
module tb_sipo_rx;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    logic       clk = 0, rst_n_i = 0, d_i = 0, valid_i = 0, ready_i = 0;
    logic       ready1, valid1, ready0, valid0;
    logic [7:0] d1, d0;
    logic [4:0] c1, c0;
    int n_chk = 0, n_pass = 0;
    int q_m[$], q_l[$];
    int nb = 0, pm = 0, pl = 0, popped = 0, pushed = 0;

    sipo_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n_i(rst_n_i), .d_i(d_i), .valid_i(valid_i), .ready_o(ready1),
        .d_o(d1), .valid_o(valid1), .ready_i(ready_i), .count_o(c1));
    sipo_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n_i(rst_n_i), .d_i(d_i), .valid_i(valid_i), .ready_o(ready0),
        .d_o(d0), .valid_o(valid0), .ready_i(ready_i), .count_o(c0));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic bit m_ready();
        return !(q_m.size() == DEPTH && nb == WIDTH - 1);
    endfunction

    function automatic void model_reset();
        q_m.delete(); q_l.delete();
        nb = 0; pm = 0; pl = 0;
    endfunction

    // compare all outputs to the model, then clock one edge and advance the model
    task automatic step(input logic v, input logic d, input logic r);
        bit rdy;
        valid_i = v; d_i = d; ready_i = r;
        rdy = m_ready();
        chk("ready_o",     32'(ready1), 32'(rdy));
        chk("ready_o_lsb", 32'(ready0), 32'(rdy));
        chk("valid_o",     32'(valid1), 32'(q_m.size() != 0));
        chk("valid_o_lsb", 32'(valid0), 32'(q_m.size() != 0));
        chk("count_o",     32'(c1), q_m.size());
        chk("count_o_lsb", 32'(c0), q_m.size());
        chk("d_o",         32'(d1), q_m.size() != 0 ? q_m[0] : 0);
        chk("d_o_lsb",     32'(d0), q_l.size() != 0 ? q_l[0] : 0);
        @(posedge clk);
        if (r && q_m.size() != 0) begin
            void'(q_m.pop_front()); void'(q_l.pop_front()); popped++;
        end
        if (v && rdy) begin
            pm = ((pm << 1) | int'(d)) & 8'hFF;
            pl = pl | (int'(d) << nb);
            nb++;
            if (nb == WIDTH) begin
                q_m.push_back(pm); q_l.push_back(pl); pushed++;
                nb = 0; pm = 0; pl = 0;
            end
        end
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input logic r, input int gap);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            repeat (gap > 0 ? $urandom_range(0, gap) : 0) step(1'b0, 1'($urandom_range(0, 1)), r);
            step(1'b1, w[i], r);
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 4 * DEPTH && q_m.size() != 0; c++) step(1'b0, 1'b0, 1'b1);
        chk("drain_count", 32'(c1), 0);
    endtask

    initial begin
        #12;
        chk("rst_valid", 32'(valid1), 0);
        chk("rst_count", 32'(c1), 0);
        chk("rst_d",     32'(d1), 0);
        chk("rst_ready", 32'(ready1), 1);
        rst_n_i = 1;
        @(posedge clk); #1;

        // single A5 word, back to back, consumer ready
        send_word(8'hA5, 1'b1, 0);
        chk("t1_d",     32'(d1), 32'hA5);
        chk("t1_valid", 32'(valid1), 1);
        chk("t1_count", 32'(c1), 1);
        step(1'b0, 1'b0, 1'b1);
        chk("t1_valid_drop", 32'(valid1), 0);
        chk("t1_count_zero", 32'(c1), 0);

        // fill FIFO, stall on the completing bit of word 17
        for (int w = 0; w < DEPTH; w++) send_word(8'(w), 1'b0, 0);
        chk("t2_full_count", 32'(c1), 16);
        for (int i = WIDTH - 1; i >= 1; i--) step(1'b1, 1'((8'h11 >> i) & 1), 1'b0);
        chk("t2_stall", 32'(ready1), 0);
        chk("t2_head", 32'(d1), 32'h00);
        step(1'b1, 1'b1, 1'b1);
        chk("t2_ready_back", 32'(ready1), 1);
        chk("t2_count_pop", 32'(c1), 15);
        step(1'b1, 1'b1, 1'b0);
        chk("t2_count_push", 32'(c1), 16);
        drain();

        // idle gaps between bits
        send_word(8'hA5, 1'b1, 5);
        chk("t3_d", 32'(d1), 32'hA5);
        drain();

        // completing bit in the same cycle as a pop
        send_word(8'h5A, 1'b0, 0);
        for (int i = WIDTH - 1; i >= 1; i--) step(1'b1, 1'((8'hC3 >> i) & 1), 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("t4_count", 32'(c1), 1);
        chk("t4_order", 32'(d1), 32'hC3);
        drain();

        // asynchronous reset with queued words and a partial word
        send_word(8'h12, 1'b0, 0);
        send_word(8'h34, 1'b0, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        #2 rst_n_i = 0;
        valid_i = 0;
        #1;
        chk("t5_valid", 32'(valid1), 0);
        chk("t5_count", 32'(c1), 0);
        chk("t5_ready", 32'(ready1), 1);
        model_reset();
        #2 rst_n_i = 1;
        @(posedge clk); #1;
        send_word(8'h3C, 1'b0, 0);
        chk("t5_word", 32'(d1), 32'h3C);
        drain();

        // random traffic, both bit orders checked against the model
        pushed = 0; popped = 0;
        for (int c = 0; c < 4000 && pushed < 50; c++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        chk("t6_pushed", pushed, 50);
        drain();
        chk("t6_popped", popped, 50);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
